// File: rtl/btn_debounce_pulse_if.sv
// Button conditioning bundle: raw board buttons in, debounced levels and press pulses out.
interface btn_debounce_pulse_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             any_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  any_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output any_pulse
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Per-button 2-FF synchronizer, debounce FSM and one-cycle press pulse for the game FSMs.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_pulse #(
  parameter int unsigned N_BTN            = 5,
  parameter int unsigned DEBOUNCE_CYC     = 500000,
  parameter int unsigned CNT_W            = 20,
  parameter int unsigned REPEAT_DELAY_CYC = 25000000,
  parameter int unsigned REPEAT_RATE_CYC  = 5000000
) (
  input logic                 board_clk,
  input logic                 Reset,
  btn_debounce_pulse_if.slave btn
);

  typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRelease} state_e;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, pulse_q, fire;
  logic             any_q;
  state_e           state_q [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE_CYC - 1);

  // rep_q marks that the initial delay has elapsed; rc then counts the repeat interval.
  logic [CNT_W-1:0] rc_q [N_BTN];
  logic [N_BTN-1:0] rep_q, rep_hit;

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      rep_hit[i] = rep_q[i] ? (rc_q[i] == RateLast) : (rc_q[i] == DelayLast);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY_CYC, REPEAT_RATE_CYC};
`endif

  always_comb begin
    fire = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      fire[i] = sync2_q[i] && (state_q[i] == StDebPress) && (cnt_q[i] == DebLast);
`ifdef BTN_AUTOREPEAT_EN
      fire[i] = fire[i] || (sync2_q[i] && (state_q[i] == StPressed) && rep_hit[i]);
`endif
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rc_q[i]    <= '0;
        rep_q[i]   <= 1'b0;
`endif
      end
    end else begin
      sync1_q <= btn.btn_raw;
      sync2_q <= sync1_q;
      pulse_q <= fire;
      any_q   <= |fire;
      for (int i = 0; i < int'(N_BTN); i++) begin
        unique case (state_q[i])
          StIdle: begin
            level_q[i] <= 1'b0;
            cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rc_q[i]    <= '0;
            rep_q[i]   <= 1'b0;
`endif
            if (sync2_q[i]) begin
              state_q[i] <= StDebPress;
              cnt_q[i]   <= CntOne;
            end
          end
          StDebPress: begin
            if (!sync2_q[i]) begin
              state_q[i] <= StIdle;
              cnt_q[i]   <= '0;
            end else if (fire[i]) begin
              state_q[i] <= StPressed;
              level_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
              rc_q[i]    <= '0;
              rep_q[i]   <= 1'b0;
`endif
            end else begin
              cnt_q[i] <= cnt_q[i] + CntOne;
            end
          end
          StPressed: begin
            level_q[i] <= 1'b1;
            if (!sync2_q[i]) begin
              state_q[i] <= StDebRelease;
              cnt_q[i]   <= CntOne;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (rep_hit[i]) begin
              rc_q[i]  <= '0;
              rep_q[i] <= 1'b1;
            end else begin
              rc_q[i] <= rc_q[i] + CntOne;
            end
`endif
          end
          StDebRelease: begin
            // A bounce back to pressed keeps the level high and never re-pulses.
            if (sync2_q[i]) begin
              state_q[i] <= StPressed;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == DebLast) begin
              state_q[i] <= StIdle;
              level_q[i] <= 1'b0;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntOne;
            end
          end
          default: state_q[i] <= StIdle;
        endcase
      end
    end
  end

  assign btn.btn_level = level_q;
  assign btn.btn_pulse = pulse_q;
  assign btn.any_pulse = any_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=6.
module tb_btn_debounce_pulse;

  logic board_clk = 1'b0;
  logic Reset;

  btn_debounce_pulse_if #(.N_BTN(5)) bif ();

  btn_debounce_pulse #(
    .N_BTN           (5),
    .DEBOUNCE_CYC    (8),
    .CNT_W           (5),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC (6)
  ) dut (
    .board_clk(board_clk),
    .Reset    (Reset),
    .btn      (bif.slave)
  );

  always #5 board_clk = ~board_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle log; index j holds outputs after the (j+1)-th rising edge since clear_log.
  logic [4:0] lg_pulse [128];
  logic [4:0] lg_level [128];
  logic       lg_any   [128];
  int         lg_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    lg_n = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge board_clk);
      @(negedge board_clk);
      lg_pulse[lg_n] = bif.btn_pulse;
      lg_level[lg_n] = bif.btn_level;
      lg_any[lg_n]   = bif.any_pulse;
      lg_n++;
    end
  endtask

  function automatic int pulse_count(input int b);
    int c = 0;
    for (int j = 0; j < lg_n; j++) if (lg_pulse[j][b]) c++;
    return c;
  endfunction

  function automatic logic level_ever(input int b);
    logic seen = 1'b0;
    for (int j = 0; j < lg_n; j++) seen |= lg_level[j][b];
    return seen;
  endfunction

  function automatic logic level_all(input int b, input int from, input int to);
    logic all_set = 1'b1;
    for (int j = from; j <= to; j++) all_set &= lg_level[j][b];
    return all_set;
  endfunction

`ifdef BTN_AUTOREPEAT_EN
  localparam int Hold40Pulses = 4;
  localparam int Hold60Pulses = 7;
`else
  localparam int Hold40Pulses = 1;
  localparam int Hold60Pulses = 1;
`endif

  initial begin
    Reset       = 1'b1;
    bif.btn_raw = 5'h1F;

    // All buttons held through reset: outputs stay quiet.
    clear_log();
    run(5);
    for (int j = 0; j < 5; j++) begin
      check_eq("rst_level", {27'd0, lg_level[j]}, 32'h0);
      check_eq("rst_pulse", {27'd0, lg_pulse[j]}, 32'h0);
      check_eq("rst_any", {31'd0, lg_any[j]}, 32'h0);
    end

    // Release reset with all held: every channel pulses at cycle 10.
    Reset = 1'b0;
    clear_log();
    run(14);
    check_eq("all_pulse_c9", {27'd0, lg_pulse[8]}, 32'h0);
    check_eq("all_pulse_c10", {27'd0, lg_pulse[9]}, 32'h1F);
    check_eq("all_pulse_c11", {27'd0, lg_pulse[10]}, 32'h0);
    check_eq("all_any_c9", {31'd0, lg_any[8]}, 32'h0);
    check_eq("all_any_c10", {31'd0, lg_any[9]}, 32'h1);
    check_eq("all_level_c9", {27'd0, lg_level[8]}, 32'h0);
    check_eq("all_level_c10", {27'd0, lg_level[9]}, 32'h1F);
    check_eq("all_level_c14", {27'd0, lg_level[13]}, 32'h1F);

    // Release all: level drops at cycle 10 after release, never a pulse.
    bif.btn_raw = 5'h00;
    clear_log();
    run(14);
    check_eq("rel_level_c9", {27'd0, lg_level[8]}, 32'h1F);
    check_eq("rel_level_c10", {27'd0, lg_level[9]}, 32'h0);
    check_eq("rel_no_pulse", pulse_count(0) + pulse_count(4), 0);

    // Short glitch on btn 0 is rejected.
    clear_log();
    bif.btn_raw = 5'h01;
    run(5);
    bif.btn_raw = 5'h00;
    run(15);
    check_eq("glitch_pulse", pulse_count(0), 0);
    check_eq("glitch_level", {31'd0, level_ever(0)}, 32'h0);

    // Btn 1 held 40 cycles.
    clear_log();
    bif.btn_raw = 5'h02;
    run(40);
    bif.btn_raw = 5'h00;
    run(14);
    check_eq("hold_pulse_c10", {31'd0, lg_pulse[9][1]}, 32'h1);
    check_eq("hold_pulse_cnt", pulse_count(1), Hold40Pulses);
    check_eq("hold_level_c49", {31'd0, lg_level[48][1]}, 32'h1);
    check_eq("hold_level_c50", {31'd0, lg_level[49][1]}, 32'h0);

    // Btn 2 release bounce of 3 cycles.
    clear_log();
    bif.btn_raw = 5'h04;
    run(12);
    bif.btn_raw = 5'h00;
    run(3);
    bif.btn_raw = 5'h04;
    run(10);
    check_eq("bounce_level", {31'd0, level_all(2, 9, 24)}, 32'h1);
    check_eq("bounce_pulse_cnt", pulse_count(2), 1);
    bif.btn_raw = 5'h00;
    run(14);

    // Btn 3: reset mid-debounce, then re-press after reset.
    clear_log();
    bif.btn_raw = 5'h08;
    run(8);
    Reset = 1'b1;
    run(2);
    check_eq("midrst_pulse", pulse_count(3), 0);
    check_eq("midrst_level", {27'd0, lg_level[9]}, 32'h0);
    Reset = 1'b0;
    clear_log();
    run(12);
    check_eq("postrst_pulse_c9", {31'd0, lg_pulse[8][3]}, 32'h0);
    check_eq("postrst_pulse_c10", {31'd0, lg_pulse[9][3]}, 32'h1);
    check_eq("postrst_pulse_cnt", pulse_count(3), 1);
    bif.btn_raw = 5'h00;
    run(14);

    // Btn 4 held 60 cycles: auto-repeat train when enabled, single pulse otherwise.
    clear_log();
    bif.btn_raw = 5'h10;
    run(60);
    bif.btn_raw = 5'h00;
    run(14);
    check_eq("long_pulse_cnt", pulse_count(4), Hold60Pulses);
    check_eq("long_pulse_c10", {31'd0, lg_pulse[9][4]}, 32'h1);
`ifdef BTN_AUTOREPEAT_EN
    check_eq("rep_pulse_c29", {31'd0, lg_pulse[28][4]}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      check_eq("rep_pulse", {31'd0, lg_pulse[29 + 6 * k][4]}, 32'h1);
      check_eq("rep_any", {31'd0, lg_any[29 + 6 * k]}, 32'h1);
    end
`else
    check_eq("norep_pulse_c30", {31'd0, lg_pulse[29][4]}, 32'h0);
    check_eq("norep_any_c30", {31'd0, lg_any[29]}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
